dot_product_memory_reader: RTL and testbench

- Read side of the dot-product datapath: fetches element pairs A[i], B[i] from two synchronous-read input memories and streams them to the dot-product unit.
- Uses a valid/ready handshake with a 2-entry skid FIFO, so downstream backpressure never loses memory read data.
- Started by the controller with a base address and a vector length; signals completion with a one-cycle pulse.

---
 rtl/dot_product_memory_reader.sv | 263 ++++++++++++++++++++++++++
 tb/tb_dot_product_memory_reader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_memory_reader.sv
// -----------------------------------------------------------------------------
// dot_product_memory_reader
//
// Read side of the dot-product datapath. On a start request it fetches element
// pairs A[i], B[i] (i = 0 .. vec_len-1) from two synchronous-read memories that
// share one address, and streams them to the dot-product unit over a
// valid/ready handshake. A small skid buffer absorbs the reads still in flight
// when the consumer stalls, so no returning memory data is ever lost.
//
// Ports
//   clk           rising-edge clock for all state
//   rst           synchronous, active-high reset
//   start_reading one-cycle start request, honoured only while idle
//   base_addr     address of element 0, captured on an accepted start
//   vec_len       number of pairs (0 .. 2^ADDRESS_WIDTH), captured on start
//   rden, rdaddr  registered read request shared by memories A and B
//   rddata_a/b    memory data, valid exactly one cycle after rden
//   elem_a/b      pair presented to the dot-product unit
//   elem_valid    elem_a, elem_b and elem_last are valid
//   elem_last     marks the final pair of the vector
//   elem_ready    consumer accepts the pair when elem_valid is also high
//   busy          high from an accepted start until done_reading
//   done_reading  one-cycle pulse the cycle after the final handshake
// -----------------------------------------------------------------------------
module dot_product_memory_reader #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_reading,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   vec_len,
  output logic                     rden,
  output logic [ADDRESS_WIDTH-1:0] rdaddr,
  input  logic [DATA_WIDTH-1:0]    rddata_a,
  input  logic [DATA_WIDTH-1:0]    rddata_b,
  output logic [DATA_WIDTH-1:0]    elem_a,
  output logic [DATA_WIDTH-1:0]    elem_b,
  output logic                     elem_valid,
  output logic                     elem_last,
  input  logic                     elem_ready,
  output logic                     busy,
  output logic                     done_reading
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDRESS_WIDTH:0] COUNT_ZERO = '0;
  localparam logic [ADDRESS_WIDTH:0] COUNT_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  state_t state, state_next;

  // Transfer bookkeeping
  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [ADDRESS_WIDTH:0]   len_q;
  logic [ADDRESS_WIDTH:0]   issue_count;
  logic [ADDRESS_WIDTH:0]   accept_count;

  // Read pipeline: rden is the read presented to the memories this cycle,
  // inflight marks the read whose data is on rddata_a/b this cycle.
  logic rden_last;
  logic inflight;
  logic inflight_last;

  // Skid buffer: elem_a/elem_b/head_last are the output slot, skid0/skid1 are
  // the two entries behind it that catch reads returning during a stall.
  logic [1:0]            fifo_count;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] skid0_a, skid0_b, skid1_a, skid1_b;
  logic                  skid0_last, skid1_last;

  logic                     pop;
  logic                     push;
  logic                     start_accept;
  logic [2:0]               occupancy;
  logic [1:0]               wr_idx;
  logic                     issue_now;
  logic                     issue_last;
  logic [ADDRESS_WIDTH-1:0] issue_addr;

  assign elem_valid   = (fifo_count != 2'd0);
  assign elem_last    = head_last & elem_valid;
  assign pop          = elem_valid & elem_ready;
  assign push         = inflight;
  assign start_accept = (state == IDLE) && start_reading;

  // Entries that will sit in the buffer after this edge. A new read is only
  // issued while that is below 2, which leaves room for the read already on
  // rden plus the new one even if the consumer stalls from now on.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

  // Slot the incoming pair lands in, after any shift caused by a pop.
  assign wr_idx = fifo_count - {1'b0, pop};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        // A zero-length vector still spends one busy cycle in DRAIN, where the
        // accept counter already matches, before signalling done.
        if (start_reading) state_next = (vec_len == COUNT_ZERO) ? DRAIN : READ;
      end
      READ: begin
        if (issue_count == len_q) state_next = DRAIN;
      end
      DRAIN: begin
        if ((pop && elem_last) || (accept_count == len_q)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and read-issue decision
  // ---------------------------------------------------------------------------
  always_comb begin
    busy         = 1'b0;
    done_reading = 1'b0;
    issue_now    = 1'b0;
    issue_addr   = base_q + issue_count[ADDRESS_WIDTH-1:0];
    issue_last   = ((issue_count + COUNT_ONE) == len_q);
    unique case (state)
      IDLE: begin
        // The first read goes out straight from the start request so that
        // rden is already high the cycle after start.
        if (start_reading && (vec_len != COUNT_ZERO)) begin
          issue_now  = 1'b1;
          issue_addr = base_addr;
          issue_last = (vec_len == COUNT_ONE);
        end
      end
      READ: begin
        busy      = 1'b1;
        issue_now = (issue_count != len_q) && (occupancy < 3'd2);
      end
      DRAIN: begin
        busy = 1'b1;
      end
      DONE: begin
        done_reading = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read request and transfer counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rden          <= 1'b0;
      rdaddr        <= '0;
      rden_last     <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      base_q        <= '0;
      len_q         <= '0;
      issue_count   <= '0;
      accept_count  <= '0;
    end else begin
      rden          <= issue_now;
      inflight      <= rden;
      inflight_last <= rden_last;
      if (issue_now) begin
        rdaddr    <= issue_addr;
        rden_last <= issue_last;
      end
      if (start_accept) begin
        base_q       <= base_addr;
        len_q        <= vec_len;
        issue_count  <= issue_now ? COUNT_ONE : COUNT_ZERO;
        accept_count <= COUNT_ZERO;
      end else begin
        if (issue_now) issue_count  <= issue_count + COUNT_ONE;
        if (pop)       accept_count <= accept_count + COUNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------------
  // NOTE: the storage slots are reset as well, because the output slot drives
  // elem_a/elem_b directly and those must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count <= 2'd0;
      elem_a     <= '0;
      elem_b     <= '0;
      head_last  <= 1'b0;
      skid0_a    <= '0;
      skid0_b    <= '0;
      skid0_last <= 1'b0;
      skid1_a    <= '0;
      skid1_b    <= '0;
      skid1_last <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase

      // Shift only when something remains behind the head, so the last
      // delivered pair stays on elem_a/elem_b once the buffer runs empty.
      if (pop && (fifo_count >= 2'd2)) begin
        elem_a     <= skid0_a;
        elem_b     <= skid0_b;
        head_last  <= skid0_last;
        skid0_a    <= skid1_a;
        skid0_b    <= skid1_b;
        skid0_last <= skid1_last;
      end

      // The write comes after the shift so it wins on the slot it targets.
      if (push) begin
        case (wr_idx)
          2'd0: begin
            elem_a    <= rddata_a;
            elem_b    <= rddata_b;
            head_last <= inflight_last;
          end
          2'd1: begin
            skid0_a    <= rddata_a;
            skid0_b    <= rddata_b;
            skid0_last <= inflight_last;
          end
          2'd2: begin
            skid1_a    <= rddata_a;
            skid1_b    <= rddata_b;
            skid1_last <= inflight_last;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dot_product_memory_reader.sv
// -----------------------------------------------------------------------------
// tb_dot_product_memory_reader
//
// Self-checking bench for dot_product_memory_reader. Two behavioural memories
// answer the reads; the expected pair stream for each vector is built from the
// memory contents, base address and length alone, then compared against every
// handshake. Timing, stall stability, address wrap, zero-length vectors, abort
// by reset and ignored restarts are covered by directed steps, followed by a
// few randomized vectors under random backpressure.
// -----------------------------------------------------------------------------
module tb_dot_product_memory_reader;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_reading;
  logic [AW-1:0] base_addr;
  logic [AW:0]   vec_len;
  logic          rden;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] rddata_a = '0;
  logic [DW-1:0] rddata_b = '0;
  logic [DW-1:0] elem_a;
  logic [DW-1:0] elem_b;
  logic          elem_valid;
  logic          elem_last;
  logic          elem_ready;
  logic          busy;
  logic          done_reading;

  dot_product_memory_reader #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_reading(start_reading),
    .base_addr    (base_addr),
    .vec_len      (vec_len),
    .rden         (rden),
    .rdaddr       (rdaddr),
    .rddata_a     (rddata_a),
    .rddata_b     (rddata_b),
    .elem_a       (elem_a),
    .elem_b       (elem_b),
    .elem_valid   (elem_valid),
    .elem_last    (elem_last),
    .elem_ready   (elem_ready),
    .busy         (busy),
    .done_reading (done_reading)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories; junk on the data bus when no read was issued,
  // so a capture on the wrong cycle shows up as a data error.
  logic [DW-1:0] mem_a [0:255];
  logic [DW-1:0] mem_b [0:255];

  always @(posedge clk) begin
    if (rden) begin
      rddata_a <= mem_a[rdaddr];
      rddata_b <= mem_b[rdaddr];
    end else begin
      rddata_a <= $urandom;
      rddata_b <= $urandom;
    end
  end

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          last;
  } pair_t;

  pair_t exp_q[$];
  bit    ready_pattern [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge: outputs are sampled and
  // inputs for the new cycle are driven from here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rden"},         rden,         1'b0);
    check({tag, "_rdaddr"},       rdaddr,       '0);
    check({tag, "_elem_a"},       elem_a,       '0);
    check({tag, "_elem_b"},       elem_b,       '0);
    check({tag, "_elem_valid"},   elem_valid,   1'b0);
    check({tag, "_elem_last"},    elem_last,    1'b0);
    check({tag, "_busy"},         busy,         1'b0);
    check({tag, "_done_reading"}, done_reading, 1'b0);
  endtask

  // One vector transfer. mode: 0 = ready always high, 1 = fixed toggling
  // pattern, 2 = random ready. rst_at > 0 aborts the run with a reset in that
  // cycle. second_start pulses another start while busy. timing enables the
  // exact-latency checks for the ready-always-high and zero-length cases.
  task automatic run_vector(input logic [AW-1:0] base, input logic [AW:0] len,
                            input int mode, input int rst_at,
                            input bit second_start, input bit timing);
    int            issued, accepted, last_hs, done_cnt, done_k;
    int            first_rden, last_rden, first_valid, budget;
    bit            r, exp_done, exp_busy;
    bit            prev_valid, prev_ready, prev_last;
    logic [DW-1:0] prev_a, prev_b;
    logic [AW-1:0] exp_addr;
    pair_t         e;

    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      exp_addr = base + i[AW-1:0];
      e.a      = mem_a[exp_addr];
      e.b      = mem_b[exp_addr];
      e.last   = (i == int'(len) - 1);
      exp_q.push_back(e);
    end

    issued = 0; accepted = 0; last_hs = -1; done_cnt = 0; done_k = -1;
    first_rden = -1; last_rden = -1; first_valid = -1;
    prev_valid = 0; prev_ready = 0; prev_last = 0; prev_a = '0; prev_b = '0;
    budget = int'(len) * 8 + 20;

    // Cycle 0: start request
    start_reading = 1'b1;
    base_addr     = base;
    vec_len       = len;
    elem_ready    = (mode == 0);

    for (int k = 1; k <= budget; k++) begin
      next_cycle();
      start_reading = second_start && (k == 2);
      if (start_reading) begin
        base_addr = AW'($urandom);
        vec_len   = (AW+1)'(3);
      end

      if (k == rst_at) begin
        rst        = 1'b1;
        elem_ready = 1'b1;
        next_cycle();
        rst = 1'b0;
        check_all_zero("abort");
        repeat (3) begin
          next_cycle();
          check("abort_rden",       rden,         1'b0);
          check("abort_elem_valid", elem_valid,   1'b0);
          check("abort_done",       done_reading, 1'b0);
          check("abort_busy",       busy,         1'b0);
        end
        exp_q.delete();
        elem_ready = 1'b0;
        return;
      end

      // Read request side
      if (rden) begin
        exp_addr = base + issued[AW-1:0];
        check("rdaddr", rdaddr, exp_addr);
        // Pairs buffered or returning this cycle, not yet accepted.
        check("occupancy_le_2", (issued - accepted) <= 2, 1'b1);
        issued++;
        check("read_count", issued <= int'(len), 1'b1);
        if (first_rden < 0) first_rden = k;
        last_rden = k;
      end

      // Completion and busy
      if (len == '0) exp_done = (k == 2);
      else exp_done = (last_hs >= 0) && (accepted == int'(len)) && (k == last_hs + 1);
      exp_busy = (done_k < 0) && !exp_done;
      check("done_reading", done_reading, exp_done);
      check("busy", busy, exp_busy);
      if (done_reading) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end

      // Stall stability and hold-when-empty
      if (prev_valid && !prev_ready) begin
        check("stall_valid", elem_valid, 1'b1);
        check("stall_a",     elem_a,     prev_a);
        check("stall_b",     elem_b,     prev_b);
        check("stall_last",  elem_last,  prev_last);
      end
      if (!elem_valid && k > 1) begin
        check("hold_a", elem_a, prev_a);
        check("hold_b", elem_b, prev_b);
      end

      // Consumer
      case (mode)
        0:       r = 1'b1;
        1:       r = ready_pattern[k % 6];
        default: r = 1'($urandom_range(0, 1));
      endcase
      elem_ready = r;
      if (elem_valid && first_valid < 0) first_valid = k;
      if (elem_valid && r) begin
        if (exp_q.size() == 0) begin
          check("extra_pair", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("elem_a",    elem_a,    e.a);
          check("elem_b",    elem_b,    e.b);
          check("elem_last", elem_last, e.last);
        end
        accepted++;
        last_hs = k;
      end

      prev_valid = elem_valid;
      prev_ready = r;
      prev_a     = elem_a;
      prev_b     = elem_b;
      prev_last  = elem_last;

      if (done_k >= 0 && k >= done_k + 2) break;
    end

    check("done_count",    done_cnt,     1);
    check("all_delivered", exp_q.size(), 0);
    check("issued_total",  issued,       int'(len));

    if (timing) begin
      if (len == '0) begin
        check("zero_no_rden",  first_rden,  -1);
        check("zero_no_valid", first_valid, -1);
        check("zero_done_at",  done_k,      2);
      end else if (mode == 0) begin
        check("first_rden_at",  first_rden,  1);
        check("last_rden_at",   last_rden,   int'(len));
        check("first_valid_at", first_valid, 3);
        check("done_at",        done_k,      int'(len) + 3);
      end
    end
    elem_ready    = 1'b0;
    start_reading = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    start_reading = 1'b0;
    base_addr     = '0;
    vec_len       = '0;
    elem_ready    = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end

    next_cycle();
    next_cycle();
    check_all_zero("reset");
    rst = 1'b0;
    next_cycle();

    // Known data at 0x10: A[i] = i+1, B[i] = 2*(i+1)
    for (int i = 0; i < 4; i++) begin
      mem_a[8'h10 + i] = DW'(i + 1);
      mem_b[8'h10 + i] = DW'(2 * (i + 1));
    end
    run_vector(8'h10, 9'd4, 0, 0, 1'b0, 1'b1);
    next_cycle();

    // Toggling backpressure
    run_vector(8'h33, 9'd5, 1, 0, 1'b0, 1'b0);
    next_cycle();

    // Zero-length vector
    run_vector(8'h20, 9'd0, 0, 0, 1'b0, 1'b1);
    next_cycle();

    // Address wrap
    run_vector(8'd254, 9'd4, 0, 0, 1'b0, 1'b1);
    next_cycle();

    // Reset two cycles after first elem_valid, then a fresh short vector
    run_vector(8'h50, 9'd8, 0, 5, 1'b0, 1'b0);
    run_vector(8'h60, 9'd2, 0, 0, 1'b0, 1'b1);
    next_cycle();

    // Restart pulse while busy must be ignored
    run_vector(8'h40, 9'd4, 0, 0, 1'b1, 1'b1);
    next_cycle();

    // Randomized vectors under random backpressure
    repeat (6) begin
      run_vector(AW'($urandom), (AW+1)'($urandom_range(1, 24)), 2, 0, 1'b0, 1'b0);
      next_cycle();
    end

    // Maximum length, wrapping through the whole address space
    run_vector(8'h80, 9'd256, 0, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
